// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: access-size encodings and controller states shared by the memory access controller.
package rv_mem_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ST_SETUP, ST_COMMIT, ERR} state_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        return size == SZ_WORD ? 3'd4 : size == SZ_HALF ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/ls_check.sv
// ls_check: flags misaligned, invalid-size or out-of-range data accesses.
module ls_check
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_DEPTH = 64
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [1:0]        i_size,
    output logic              o_err
);
    logic [ADDR_W:0] w_end;
    logic            w_misalign;

    assign w_end      = {1'b0, i_addr} + (ADDR_W+1)'(size_bytes(i_size));
    assign w_misalign = (i_size == SZ_WORD && i_addr[1:0] != 2'b00) || (i_size == SZ_HALF && i_addr[0]) || i_size == SZ_BAD;
    assign o_err      = w_misalign || w_end > (ADDR_W+1)'(DATA_DEPTH);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates instruction fetches and load/stores onto one phase-multiplexed memory port.
module mem_access_ctrl
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_valid,
    output logic [31:0]       if_inst,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic              ls_signed,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_ack,
    output logic              ls_valid,
    output logic              ls_err,
    output logic [31:0]       ls_rdata,
    output logic              mem_sel,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_signed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    state_t            r_state, w_next;
    logic              w_idle, w_ls_err, w_ls_done;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata, r_if_inst, r_ls_rdata;
    logic [1:0]        r_mem_size;
    logic              r_mem_signed, r_if_valid, r_ls_valid, r_ls_err;

    ls_check #(.ADDR_W(ADDR_W), .DATA_DEPTH(DATA_DEPTH)) u_ls_check (
        .i_addr(ls_addr),
        .i_size(ls_size),
        .o_err (w_ls_err)
    );

    assign w_idle    = r_state == IDLE;
    assign ls_ack    = w_idle & ls_req;
    assign if_ack    = w_idle & if_req & ~ls_req;
    assign w_ls_done = r_state inside {LOAD, ST_COMMIT, ERR};

    always_ff @(posedge clk) begin
        r_state <= !rst_n ? IDLE : w_next;
    end

    always_comb begin
        w_next = w_idle ? (ls_ack ? (w_ls_err ? ERR : ls_we ? ST_SETUP : LOAD) : if_ack ? FETCH : IDLE)
               : r_state == ST_SETUP ? ST_COMMIT : IDLE;
    end

    // Writes commit on the falling edge of mem_sel, so it drops only in LOAD and ST_COMMIT.
    always_comb begin
        mem_sel   = !(r_state == LOAD || r_state == ST_COMMIT);
        mem_read  = r_state == LOAD;
        mem_write = r_state == ST_SETUP || r_state == ST_COMMIT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_size   <= SZ_WORD;
            r_mem_signed <= 1'b0;
            r_if_valid   <= 1'b0;
            r_ls_valid   <= 1'b0;
            r_ls_err     <= 1'b0;
            r_if_inst    <= '0;
            r_ls_rdata   <= '0;
        end else begin
            if (ls_ack) begin
                r_mem_addr   <= ls_addr;
                r_mem_wdata  <= ls_wdata;
                r_mem_size   <= ls_size;
                r_mem_signed <= ls_signed;
            end else if (if_ack) begin
                r_mem_addr <= if_addr;
            end
            r_if_valid <= r_state == FETCH;
            r_ls_valid <= w_ls_done;
            r_ls_err   <= r_state == ERR;
            if (r_state == FETCH) r_if_inst <= mem_rdata;
            if (w_ls_done) r_ls_rdata <= r_state == LOAD ? mem_rdata : '0;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_size   = r_mem_size;
    assign mem_signed = r_mem_signed;
    assign if_valid   = r_if_valid;
    assign if_inst    = r_if_inst;
    assign ls_valid   = r_ls_valid;
    assign ls_err     = r_ls_err;
    assign ls_rdata   = r_ls_rdata;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized scoreboard bench for mem_access_ctrl with a phase-driven memory model.
module tb_mem_access_ctrl;
    localparam int AW    = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, ls_signed = 1'b0;
    logic [AW-1:0] if_addr = '0, ls_addr = '0;
    logic [1:0]    ls_size = 2'b00;
    logic [31:0]   ls_wdata = '0;
    logic          if_ack, if_valid, ls_ack, ls_valid, ls_err;
    logic [31:0]   if_inst, ls_rdata, mem_wdata, mem_rdata;
    logic          mem_sel, mem_read, mem_write, mem_signed;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;

    int total = 0, bad = 0;
    logic [31:0] imem [256];
    logic [7:0]  dmem [DEPTH];
    logic [7:0]  ref_mem [DEPTH];
    logic        mem_ready = 1'b0;

    typedef struct { bit is_if; logic [31:0] data; bit err; } exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_valid(if_valid), .if_inst(if_inst),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_signed(ls_signed), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_valid(ls_valid), .ls_err(ls_err), .ls_rdata(ls_rdata),
        .mem_sel(mem_sel), .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_signed(mem_signed), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic void chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h @%0t", name, got, want, $time);
        end
    endfunction

    function automatic int nbytes(logic [1:0] s);
        return s == 2'b00 ? 4 : s == 2'b01 ? 2 : 1;
    endfunction

    function automatic int wrap(int a);
        return a % DEPTH;
    endfunction

    function automatic logic [31:0] extend(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3, logic [1:0] size, logic sgn);
        if (size == 2'b00) return {b3, b2, b1, b0};
        if (size == 2'b01) return sgn ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
        return sgn ? {{24{b0[7]}}, b0} : {24'h0, b0};
    endfunction

    function automatic logic [31:0] ref_load(int a, logic [1:0] size, logic sgn);
        return extend(ref_mem[wrap(a)], ref_mem[wrap(a+1)], ref_mem[wrap(a+2)], ref_mem[wrap(a+3)], size, sgn);
    endfunction

    // Memory: instruction words while mem_sel=1, sized data reads while 0.
    always_comb begin
        mem_rdata = mem_sel ? imem[mem_addr]
                  : extend(dmem[wrap(int'(mem_addr))], dmem[wrap(int'(mem_addr)+1)], dmem[wrap(int'(mem_addr)+2)],
                           dmem[wrap(int'(mem_addr)+3)], mem_size, mem_signed);
    end

    // Writes commit when mem_sel falls with mem_write high.
    logic          p_sel = 1'b1;
    logic [AW-1:0] p_addr = '0;
    logic [1:0]    p_size = '0;
    logic [31:0]   p_wdata = '0;
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < DEPTH; i++) dmem[i] <= 8'(i * 37 + 11);
            mem_ready <= 1'b1;
        end else if (p_sel && !mem_sel && mem_write) begin
            chk("commit_stable", 64'({p_addr, p_size, p_wdata}), 64'({mem_addr, mem_size, mem_wdata}));
            for (int i = 0; i < nbytes(mem_size); i++) dmem[wrap(int'(mem_addr) + i)] <= mem_wdata[8*i +: 8];
        end
        if (mem_read) chk("read_phase", 64'(mem_sel), 64'(0));
        p_sel   <= mem_sel;
        p_addr  <= mem_addr;
        p_size  <= mem_size;
        p_wdata <= mem_wdata;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (if_valid || ls_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("valid_kind", 64'(if_valid), 64'(e.is_if));
                if (e.is_if) begin
                    chk("if_inst", 64'(if_inst), 64'(e.data));
                end else begin
                    chk("ls_rdata", 64'(ls_rdata), 64'(e.data));
                    chk("ls_err", 64'(ls_err), 64'(e.err));
                end
            end
        end
    end

    task automatic check_reset(string tag);
        chk({tag, "_ctl"}, 64'({mem_sel, mem_read, mem_write, mem_signed, mem_size}), 64'(6'b100000));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_valids"}, 64'({if_valid, ls_valid, ls_err}), 64'(0));
        chk({tag, "_data"}, {if_inst, ls_rdata}, 64'(0));
    endtask

    task automatic do_if(input logic [AW-1:0] addr);
        bit   got;
        int   lat;
        exp_t e;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = if_ack;
        end
        chk("if_ack", 64'(got), 64'(1));
        e.is_if = 1'b1; e.data = imem[addr]; e.err = 1'b0;
        if (got) exp_q.push_back(e);
        @(posedge clk); #1;
        if_req = 1'b0;
        if (!got) return;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if_valid && lat < 10);
        chk("if_latency", 64'(lat), 64'(2));
    endtask

    task automatic do_ls(input bit we, input logic [1:0] size, input bit sgn, input logic [AW-1:0] addr, input logic [31:0] wdata);
        bit   got, err, rd_seen, wr_seen;
        int   lat, a, n;
        exp_t e;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = we; ls_size = size; ls_signed = sgn; ls_addr = addr; ls_wdata = wdata; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = ls_ack;
        end
        chk("ls_ack", 64'(got), 64'(1));
        a = int'(addr);
        n = nbytes(size);
        err = size == 2'b11 || (size == 2'b00 && a % 4 != 0) || (size == 2'b01 && a % 2 != 0) || a + n > DEPTH;
        e.is_if = 1'b0; e.err = err; e.data = '0;
        if (got && !err && we) for (int i = 0; i < n; i++) ref_mem[wrap(a + i)] = wdata[8*i +: 8];
        if (!err && !we) e.data = ref_load(a, size, sgn);
        if (got) exp_q.push_back(e);
        @(posedge clk); #1;
        ls_req = 1'b0;
        if (!got) return;
        lat = 0; rd_seen = 1'b0; wr_seen = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            rd_seen = rd_seen | mem_read;
            wr_seen = wr_seen | mem_write;
        end while (!ls_valid && lat < 10);
        chk("ls_latency", 64'(lat), 64'(err ? 2 : we ? 3 : 2));
        chk("ls_mem_en", 64'({rd_seen, wr_seen}), 64'(err ? 2'b00 : we ? 2'b01 : 2'b10));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit   seen_valid, got;
        exp_t e;
        int   lat;
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        imem[1] = 32'h00002083;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 37 + 11);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset("reset");

        do_if(8'd1);
        chk("fetch_word1", 64'(if_inst), 64'(32'h00002083));

        do_ls(1'b1, 2'b00, 1'b0, 8'd12, 32'hDEADBEEF);
        do_ls(1'b0, 2'b00, 1'b0, 8'd12, '0);
        chk("load_word12", 64'(ls_rdata), 64'(32'hDEADBEEF));
        do_ls(1'b0, 2'b10, 1'b1, 8'd12, '0);
        chk("load_sbyte12", 64'(ls_rdata), 64'(32'hFFFFFFEF));
        do_ls(1'b0, 2'b10, 1'b0, 8'd13, '0);
        chk("load_ubyte13", 64'(ls_rdata), 64'(32'h000000BE));

        // Simultaneous requests: load/store must win, fetch waits for IDLE.
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_signed = 1'b0; ls_addr = 8'd12;
        if_req = 1'b1; if_addr = 8'd5;
        @(negedge clk);
        chk("arb_ls_ack", 64'(ls_ack), 64'(1));
        chk("arb_no_if_ack", 64'(if_ack), 64'(0));
        e.is_if = 1'b0; e.err = 1'b0; e.data = ref_load(12, 2'b00, 1'b0);
        if (ls_ack) exp_q.push_back(e);
        @(posedge clk); #1;
        ls_req = 1'b0;
        seen_valid = 1'b0; got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            seen_valid = seen_valid | ls_valid;
            got = if_ack;
        end
        chk("arb_if_ack", 64'(got), 64'(1));
        chk("arb_if_after_valid", 64'(seen_valid), 64'(1));
        e.is_if = 1'b1; e.data = imem[5];
        if (got) exp_q.push_back(e);
        @(posedge clk); #1;
        if_req = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if_valid && lat < 10);
        chk("arb_if_latency", 64'(lat), 64'(2));

        do_ls(1'b0, 2'b00, 1'b0, 8'd2, '0);
        chk("err_flag", 64'({ls_err, ls_rdata}), 64'({1'b1, 32'h0}));
        do_ls(1'b0, 2'b01, 1'b0, 8'd63, '0);
        do_ls(1'b1, 2'b10, 1'b0, 8'd63, 32'h000000A5);
        do_ls(1'b0, 2'b10, 1'b1, 8'd63, '0);
        do_ls(1'b1, 2'b00, 1'b0, 8'd60, 32'h80017FFE);
        do_ls(1'b0, 2'b01, 1'b1, 8'd62, '0);
        do_ls(1'b0, 2'b00, 1'b0, 8'd64, '0);
        do_ls(1'b1, 2'b11, 1'b0, 8'd8, 32'h11111111);

        // Reset while the store sits in ST_SETUP: the write must not land.
        do_ls(1'b1, 2'b00, 1'b0, 8'd16, 32'hCAFEF00D);
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 8'd16; ls_wdata = 32'h12345678;
        @(negedge clk);
        chk("rst_store_ack", 64'(ls_ack), 64'(1));
        @(posedge clk); #1;
        ls_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        chk("setup_phase", 64'({mem_sel, mem_write}), 64'(2'b11));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");
        do_ls(1'b0, 2'b00, 1'b0, 8'd16, '0);
        chk("rst_store_dropped", 64'(ls_rdata), 64'(32'hCAFEF00D));

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) do_if(8'($urandom_range(0, 255)));
            else do_ls(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       8'($urandom_range(0, 67)), $urandom);
        end

        @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL expose parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL expose parameter DATA_DEPTH, default 64, data-memory size in bytes, used for range checking.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch request; held until if_ack.
REQ-006 if_addr  input  ADDR_W  instruction word index.
REQ-007 if_ack  output  1  fetch request accepted this cycle.
REQ-008 if_valid  output  1  one-cycle pulse: if_inst valid.
REQ-009 if_inst  output  32  fetched instruction; held until next fetch.
REQ-010 ls_req, ls_we  input  1 each  load/store request, held until ls_ack; ls_we=1 means store.
REQ-011 ls_size  input  2  00 word, 01 half, 10 byte, 11 invalid.
REQ-012 ls_signed  input  1  1 = sign-extend load.
REQ-013 ls_addr  input  ADDR_W  byte address.
REQ-014 ls_wdata  input  32  store data.
REQ-015 ls_ack  output  1  load/store request accepted this cycle.
REQ-016 ls_valid, ls_err  output  1 each  completion pulse; error flag, valid only with ls_valid.
REQ-017 ls_rdata  output  32  load result; 0 for stores and errors.
REQ-018 mem_sel  output  1  phase select to memory: 1 instruction phase, 0 data phase; memory commits writes on its falling edge.
REQ-019 mem_read, mem_write  output  1 each  data-phase read enable; write enable.
REQ-020 mem_size, mem_signed  output  2, 1  access size and signedness to memory.
REQ-021 mem_addr, mem_wdata  output  ADDR_W, 32  memory address; store data.
REQ-022 mem_rdata  input  32  combinational memory read data.

Function
REQ-023 States: IDLE, FETCH, LOAD, ST_SETUP, ST_COMMIT, ERR.
REQ-024 ls_ack = (state==IDLE) & ls_req; if_ack = (state==IDLE) & if_req & ~ls_req; load/store always wins.
REQ-025 IDLE + ls_ack: error check (misaligned word addr[1:0]!=0, misaligned half addr[0]!=0, ls_size==11, addr+bytes>DATA_DEPTH) -> ERR; else load -> LOAD, store -> ST_SETUP.
REQ-026 IDLE + if_ack -> FETCH; mem_addr=if_addr, mem_sel=1, mem_read=0.
REQ-027 FETCH: capture mem_rdata into if_inst at end of cycle; -> IDLE; if_valid pulses the following cycle (ack-to-valid latency 2).
REQ-028 LOAD: mem_sel=0, mem_read=1, mem_addr/size/signed from request; capture mem_rdata into ls_rdata; -> IDLE; ls_valid pulses next cycle, ls_err=0.
REQ-029 ST_SETUP: mem_sel=1, mem_write=1, mem_read=0, addr/size/wdata stable; -> ST_COMMIT.
REQ-030 ST_COMMIT: mem_sel falls to 0 while mem_addr, mem_size, mem_wdata and mem_write are unchanged from ST_SETUP; -> IDLE; ls_valid pulses next cycle, ls_rdata=0.
REQ-031 mem_addr, mem_size and mem_wdata SHALL never change in the same cycle that mem_sel falls.
REQ-032 ERR: no memory enable asserted; -> IDLE; ls_valid=1, ls_err=1, ls_rdata=0 in the following cycle.
REQ-033 In IDLE: mem_sel=1, mem_read=0, mem_write=0; mem_addr holds last value.
REQ-034 Requests arriving while not in IDLE SHALL be ignored until IDLE; a new request MAY be acked in the same cycle a valid pulses.

Reset
REQ-035 On rst_n=0 at a rising edge: state=IDLE, mem_sel=1, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_size=00, mem_signed=0, if_valid=0, ls_valid=0, ls_err=0, if_inst=0, ls_rdata=0.
REQ-036 Reset in ST_SETUP SHALL produce no write, because mem_sel stays 1; a write already committed on entry to ST_COMMIT stands.

Structure
REQ-037 Package rv_mem_pkg SHALL hold the size encodings (SZ_WORD/SZ_HALF/SZ_BYTE) and the state enum.
REQ-038 Sub-module ls_check SHALL compute the alignment and range error combinationally.

Verification
REQ-039 Fetch: if_addr=1 with memory word 1 = 0x00002083 -> if_ack, then if_valid 2 cycles later with if_inst=0x00002083.
REQ-040 Store, then load: store word 0xDEADBEEF at 12; then load word at 12 -> 0xDEADBEEF; signed load byte at 12 -> 0xFFFFFFEF; unsigned load byte at 13 -> 0x000000BE.
REQ-041 Arbitration: if_req and ls_req asserted in the same cycle -> ls_ack first; if_ack only after ls_valid.
REQ-042 Error: load word at 2 -> ls_valid+ls_err 2 cycles after ack; mem_read and mem_write never asserted.
REQ-043 Reset mid-store: store 0x12345678 at 16 with rst_n=0 during ST_SETUP; then load word at 16 -> prior contents unchanged.
